// File: rtl/matrix_mul_pkg.sv
// Shared definitions for the matrix multiply datapath: default operand width,
// MAC controller state encoding and the C element index map.
package matrix_mul_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  // Element index = 2*row + col; the same map addresses the A/B operand copies.
  localparam logic [1:0] IDX_C11 = 2'd0;
  localparam logic [1:0] IDX_C12 = 2'd1;
  localparam logic [1:0] IDX_C21 = 2'd2;
  localparam logic [1:0] IDX_C22 = 2'd3;

endpackage

// File: rtl/matrix_block_mac_if.sv
// Handshake and operand/result bus of the 2x2 block MAC.
// sat_flag exists only when MATRIX_MAC_SAT_EN is defined.
interface matrix_block_mac_if #(
  parameter int DATA_W = matrix_mul_pkg::DATA_W
);
  logic                     start_mac;
  logic                     acc_clr;
  logic signed [DATA_W-1:0] a_11, a_12, a_21, a_22;
  logic signed [DATA_W-1:0] b_11, b_12, b_21, b_22;
  logic signed [DATA_W-1:0] c_11, c_12, c_21, c_22;
  logic                     done_mac;
  logic                     busy;
`ifdef MATRIX_MAC_SAT_EN
  logic                     sat_flag;
`endif

  modport master (
    output start_mac, acc_clr,
    output a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    input  c_11, c_12, c_21, c_22, done_mac, busy
`ifdef MATRIX_MAC_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  start_mac, acc_clr,
    input  a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    output c_11, c_12, c_21, c_22, done_mac, busy
`ifdef MATRIX_MAC_SAT_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/matrix_block_mac_dot2.sv
// Two-term signed dot product plus accumulator: acc + x1*y1 + x2*y2.
// The sum is formed exactly at 2*DATA_W+2 bits, then either saturated to
// DATA_W bits (MATRIX_MAC_SAT_EN defined, sat reports a clamp) or wrapped.
module block_mac_dot2
  import matrix_mul_pkg::*;
#(
  parameter int DATA_W = matrix_mul_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] y1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] y2,
  input  logic signed [DATA_W-1:0] acc,
  output logic signed [DATA_W-1:0] sum
`ifdef MATRIX_MAC_SAT_EN
  , output logic                   sat
`endif
);

  localparam int SUM_W = 2*DATA_W + 2;

  logic signed [2*DATA_W-1:0] p1, p2;
  logic signed [SUM_W-1:0]    full;

`ifdef MATRIX_MAC_SAT_EN
  // Out of range when the bits above the result sign are not a pure sign extension.
  function automatic logic ovf(input logic signed [SUM_W-1:0] s);
    logic [SUM_W-DATA_W:0] hi;
    hi = s[SUM_W-1:DATA_W-1];
    return !((&hi) || (~|hi));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_reduce(input logic signed [SUM_W-1:0] s);
    if (ovf(s))
      return s[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      return s[DATA_W-1:0];
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] wrap_reduce(input logic signed [SUM_W-1:0] s);
    return DATA_W'(s);
  endfunction
`endif

  // Exact products and sum, then width reduction.
  always_comb begin
    p1   = x1 * y1;
    p2   = x2 * y2;
    full = SUM_W'(p1) + SUM_W'(p2) + SUM_W'(acc);
`ifdef MATRIX_MAC_SAT_EN
    sum  = sat_reduce(full);
    sat  = ovf(full);
`else
    sum  = wrap_reduce(full);
`endif
  end

endmodule

// File: rtl/matrix_block_mac.sv
// 2x2 block multiply-accumulate engine: C += A*B over four CALC cycles using a
// single shared two-term dot-product datapath (block_mac_dot2).
// Build option: MATRIX_MAC_SAT_EN selects saturating accumulation with a
// sticky sat_flag; otherwise results wrap modulo 2^DATA_W.
module matrix_block_mac
  import matrix_mul_pkg::*;
#(
  parameter int DATA_W = matrix_mul_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  matrix_block_mac_if.slave  mac
);

  mac_state_e               state_q;
  logic [1:0]               idx_q;
  logic                     clr_q;      // block started with acc_clr: old C reads as 0
  logic signed [DATA_W-1:0] a_q [4];
  logic signed [DATA_W-1:0] b_q [4];
  logic signed [DATA_W-1:0] c_q [4];
  logic                     done_q;
  logic                     busy_q;
  logic                     sat_q;

  logic signed [DATA_W-1:0] x1, y1, x2, y2, acc, c_d;
  logic                     sat_d;

  // Select row idx[1] of A, column idx[0] of B, and the element being updated.
  always_comb begin
    x1  = a_q[{idx_q[1], 1'b0}];
    x2  = a_q[{idx_q[1], 1'b1}];
    y1  = b_q[{1'b0, idx_q[0]}];
    y2  = b_q[{1'b1, idx_q[0]}];
    acc = clr_q ? '0 : c_q[idx_q];
  end

  block_mac_dot2 #(.DATA_W(DATA_W)) u_dot2 (
    .x1  (x1),
    .y1  (y1),
    .x2  (x2),
    .y2  (y2),
    .acc (acc),
    .sum (c_d)
`ifdef MATRIX_MAC_SAT_EN
    , .sat (sat_d)
`endif
  );

`ifndef MATRIX_MAC_SAT_EN
  assign sat_d = 1'b0;
`endif

  // Controller FSM with operand latching, accumulator update and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (mac.start_mac) begin
            a_q[IDX_C11] <= mac.a_11;
            a_q[IDX_C12] <= mac.a_12;
            a_q[IDX_C21] <= mac.a_21;
            a_q[IDX_C22] <= mac.a_22;
            b_q[IDX_C11] <= mac.b_11;
            b_q[IDX_C12] <= mac.b_12;
            b_q[IDX_C21] <= mac.b_21;
            b_q[IDX_C22] <= mac.b_22;
            clr_q   <= mac.acc_clr;
            idx_q   <= IDX_C11;
            busy_q  <= 1'b1;
            state_q <= CALC;
            if (mac.acc_clr) sat_q <= 1'b0;
          end else begin
            if (mac.acc_clr) begin
              for (int k = 0; k < 4; k++) c_q[k] <= '0;
              sat_q <= 1'b0;
            end
            state_q <= IDLE;
          end
        end
        CALC: begin
          c_q[idx_q] <= c_d;
          sat_q      <= sat_q | sat_d;
          idx_q      <= idx_q + 2'd1;
          if (idx_q == IDX_C22) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mac.c_11     = c_q[IDX_C11];
  assign mac.c_12     = c_q[IDX_C12];
  assign mac.c_21     = c_q[IDX_C21];
  assign mac.c_22     = c_q[IDX_C22];
  assign mac.done_mac = done_q;
  assign mac.busy     = busy_q;
`ifdef MATRIX_MAC_SAT_EN
  assign mac.sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_matrix_block_mac.sv
// Testbench for matrix_block_mac: directed and randomized blocks checked
// against a matrix-level reference model (C = C_old + A*B, or A*B with clear).
module tb_matrix_block_mac;

  localparam int DATA_W = 32;
  typedef logic [3:0][DATA_W-1:0] mat_t;   // element 2*row+col

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_block_mac_if #(.DATA_W(DATA_W)) mac_if ();
  matrix_block_mac #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .mac(mac_if));

  int   n_tests = 0;
  int   n_fail  = 0;
  mat_t mc;      // model accumulator
  logic msat;    // model sticky saturation

`ifdef MATRIX_MAC_SAT_EN
  localparam logic signed [66:0] MAXV = 67'sd2147483647;
  localparam logic signed [66:0] MINV = -67'sd2147483648;
`endif

  function automatic mat_t get_c();
    return {mac_if.c_22, mac_if.c_21, mac_if.c_12, mac_if.c_11};
  endfunction

  function automatic mat_t rand_mat(input bit full);
    mat_t m;
    int   v;
    for (int e = 0; e < 4; e++) begin
      if (full) m[e] = $urandom;
      else begin
        v    = int'($urandom_range(0, 200)) - 100;
        m[e] = v;
      end
    end
    return m;
  endfunction

  task automatic set_ops(input mat_t a, input mat_t b);
    mac_if.a_11 = a[0]; mac_if.a_12 = a[1]; mac_if.a_21 = a[2]; mac_if.a_22 = a[3];
    mac_if.b_11 = b[0]; mac_if.b_12 = b[1]; mac_if.b_21 = b[2]; mac_if.b_22 = b[3];
  endtask

  // Reference: C[i][j] = (clr ? 0 : C[i][j]) + sum_k A[i][k]*B[k][j], then reduce.
  task automatic model_block(input mat_t a, input mat_t b, input logic clr);
    logic signed [66:0] s;
    if (clr) msat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (clr) s = '0;
        else     s = $signed(mc[2*i+j]);
        for (int k = 0; k < 2; k++)
          s = s + $signed(a[2*i+k]) * $signed(b[2*k+j]);
`ifdef MATRIX_MAC_SAT_EN
        if (s > MAXV) begin
          mc[2*i+j] = 32'h7FFF_FFFF; msat = 1'b1;
        end else if (s < MINV) begin
          mc[2*i+j] = 32'h8000_0000; msat = 1'b1;
        end else mc[2*i+j] = s[DATA_W-1:0];
`else
        mc[2*i+j] = s[DATA_W-1:0];
`endif
      end
    end
  endtask

  // One block: start with operands, scramble inputs afterwards, wait for done_mac.
  task automatic run_block(input mat_t a, input mat_t b, input logic clr,
                           output int lat, output logic busy0);
    @(negedge clk);
    set_ops(a, b);
    mac_if.start_mac = 1'b1;
    mac_if.acc_clr   = clr;
    @(posedge clk); #1;
    busy0 = mac_if.busy;
    mac_if.start_mac = 1'b0;
    mac_if.acc_clr   = 1'b0;
    set_ops(rand_mat(1), rand_mat(1));
    lat = -1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      if (mac_if.done_mac) begin lat = t; break; end
    end
    model_block(a, b, clr);
  endtask

  task automatic test_reset();
    mat_t obs;
    rst = 1'b1;
    mac_if.start_mac = 1'b0;
    mac_if.acc_clr   = 1'b0;
    set_ops('0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    mc = '0; msat = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mac_if.done_mac !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", mac_if.done_mac); end
    n_tests++;
    if (mac_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", mac_if.busy); end
    obs = get_c();
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL reset_c[%0d] got %h want %h", e, obs[e], mc[e]); end
    end
`ifdef MATRIX_MAC_SAT_EN
    n_tests++;
    if (mac_if.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", mac_if.sat_flag); end
`endif
  endtask

  task automatic test_basic();
    mat_t a, b, obs;
    int   lat;
    logic busy0;
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    b = {32'd8, 32'd7, 32'd6, 32'd5};
    for (int pass = 0; pass < 2; pass++) begin
      run_block(a, b, pass == 0, lat, busy0);
      n_tests++;
      if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic%0d_busy got %b want 1", pass, busy0); end
      n_tests++;
      if (lat !== 4) begin n_fail++; $display("FAIL basic%0d_latency got %0d want 4", pass, lat); end
      obs = get_c();
      for (int e = 0; e < 4; e++) begin
        n_tests++;
        if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL basic%0d_c[%0d] got %0d want %0d", pass, e, $signed(obs[e]), $signed(mc[e])); end
      end
      n_tests++;
      if (mac_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic%0d_busy_done got %b want 0", pass, mac_if.busy); end
    end
  endtask

  task automatic test_back_to_back();
    mat_t a, b, obs;
    int   done_cnt;
    @(negedge clk); mac_if.acc_clr = 1'b1;
    @(posedge clk); #1; mac_if.acc_clr = 1'b0;
    mc = '0; msat = 1'b0;
    a = {32'd1, 32'd0, 32'd0, 32'd1};
    b = {32'd1, 32'd1, 32'd1, 32'd1};
    @(negedge clk);
    set_ops(a, b);
    mac_if.start_mac = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk); #1;
      if (mac_if.done_mac) begin
        done_cnt++;
        n_tests++;
        if (t !== (done_cnt == 1 ? 4 : 9)) begin n_fail++; $display("FAIL b2b_done%0d_cycle got %0d want %0d", done_cnt, t, (done_cnt == 1 ? 4 : 9)); end
        model_block(a, b, 1'b0);
        obs = get_c();
        for (int e = 0; e < 4; e++) begin
          n_tests++;
          if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL b2b%0d_c[%0d] got %0d want %0d", done_cnt, e, $signed(obs[e]), $signed(mc[e])); end
        end
        if (done_cnt == 2) mac_if.start_mac = 1'b0;
      end
    end
    mac_if.start_mac = 1'b0;
    n_tests++;
    if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
  endtask

  task automatic test_abort();
    mat_t a, b, obs;
    int   dones, first_t;
    a = rand_mat(0); b = rand_mat(0);
    @(negedge clk); set_ops(a, b); mac_if.start_mac = 1'b1;
    @(posedge clk); #1; mac_if.start_mac = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    mc = '0; msat = 1'b0;
    n_tests++;
    if (mac_if.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", mac_if.busy); end
    obs = get_c();
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL abort_c[%0d] got %h want %h", e, obs[e], mc[e]); end
    end
    rst = 1'b0;
    dones = 0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      if (mac_if.done_mac) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", dones); end
    // start pulses during CALC are ignored
    a = rand_mat(0); b = rand_mat(0);
    @(negedge clk); set_ops(a, b); mac_if.start_mac = 1'b1;
    @(posedge clk); #1; set_ops(rand_mat(0), rand_mat(0));
    dones = 0; first_t = -1;
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk); #1;
      mac_if.start_mac = (t < 3);
      if (mac_if.done_mac) begin dones++; if (first_t < 0) first_t = t; end
    end
    model_block(a, b, 1'b0);
    n_tests++;
    if (dones !== 1 || first_t !== 4) begin n_fail++; $display("FAIL calc_start_ignored got %0d dones first at %0d want 1 at 4", dones, first_t); end
    obs = get_c();
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL calc_start_c[%0d] got %0d want %0d", e, $signed(obs[e]), $signed(mc[e])); end
    end
  endtask

  task automatic test_signed();
    mat_t a, b, obs;
    int   lat;
    logic busy0;
    a = {-32'sd3, 32'sd0, 32'sd0, -32'sd3};
    b = {32'sd2, 32'sd0, 32'sd0, 32'sd2};
    run_block(a, b, 1'b1, lat, busy0);
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL signed_latency got %0d want 4", lat); end
    obs = get_c();
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL signed_c[%0d] got %0d want %0d", e, $signed(obs[e]), $signed(mc[e])); end
    end
    @(negedge clk); mac_if.acc_clr = 1'b1;
    @(posedge clk); #1; mac_if.acc_clr = 1'b0;
    mc = '0; msat = 1'b0;
    obs = get_c();
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL clr_idle_c[%0d] got %0d want %0d", e, $signed(obs[e]), $signed(mc[e])); end
    end
  endtask

  task automatic test_boundary();
    mat_t a, b, obs;
    int   lat;
    logic busy0;
    logic [DATA_W-1:0] c11_req;
    a = {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    b = {32'd0, 32'd2, 32'd0, 32'd2};
    run_block(a, b, 1'b1, lat, busy0);
    obs = get_c();
`ifdef MATRIX_MAC_SAT_EN
    c11_req = 32'h7FFF_FFFF;
    n_tests++;
    if (mac_if.sat_flag !== 1'b1) begin n_fail++; $display("FAIL bound_sat got %b want 1", mac_if.sat_flag); end
`else
    c11_req = 32'hFFFF_FFFC;
`endif
    n_tests++;
    if (obs[0] !== c11_req) begin n_fail++; $display("FAIL bound_c11 got %h want %h", obs[0], c11_req); end
    for (int e = 1; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL bound_c[%0d] got %h want %h", e, obs[e], mc[e]); end
    end
    // negative overflow on c_22
    a = {32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0};
    b = {32'd3, 32'd0, 32'd3, 32'd0};
    run_block(a, b, 1'b1, lat, busy0);
    obs = get_c();
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL negbound_c[%0d] got %h want %h", e, obs[e], mc[e]); end
    end
`ifdef MATRIX_MAC_SAT_EN
    n_tests++;
    if (mac_if.sat_flag !== msat) begin n_fail++; $display("FAIL negbound_sat got %b want %b", mac_if.sat_flag, msat); end
    @(negedge clk); mac_if.acc_clr = 1'b1;
    @(posedge clk); #1; mac_if.acc_clr = 1'b0;
    mc = '0; msat = 1'b0;
    n_tests++;
    if (mac_if.sat_flag !== msat) begin n_fail++; $display("FAIL clr_sat got %b want %b", mac_if.sat_flag, msat); end
`endif
  endtask

  task automatic test_random();
    mat_t a, b, obs;
    int   lat;
    logic busy0;
    for (int n = 0; n < 12; n++) begin
      a = rand_mat($urandom_range(0, 1) == 1);
      b = rand_mat($urandom_range(0, 1) == 1);
      run_block(a, b, $urandom_range(0, 3) == 0, lat, busy0);
      n_tests++;
      if (lat !== 4) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 4", n, lat); end
      obs = get_c();
      for (int e = 0; e < 4; e++) begin
        n_tests++;
        if (obs[e] !== mc[e]) begin n_fail++; $display("FAIL rand%0d_c[%0d] got %h want %h", n, e, obs[e], mc[e]); end
      end
`ifdef MATRIX_MAC_SAT_EN
      n_tests++;
      if (mac_if.sat_flag !== msat) begin n_fail++; $display("FAIL rand%0d_sat got %b want %b", n, mac_if.sat_flag, msat); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_signed();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
